// File: rtl/game_pkg.sv
// Shared types and constants for the game board UART path.
// Arbiter state encoding, refresh period and timer sizing.
package game_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEND,
    ARB_GAP
  } arb_state_t;

  // ~6.5 ms at 100 MHz
  localparam int UART_REFRESH_CYC = 650000;

  function automatic int cnt_w(int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from last+1, wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx,
  output logic                      any
);

  localparam int IW = $clog2(NUM_CH);

  logic [IW-1:0] cand;
  logic          found;

  // first requester after the previous grant wins
  always_comb begin
    gnt_idx = last;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IW'((int'(last) + i) % NUM_CH);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding changed channel bytes to the UART TX FIFO.
// Tracks per-channel changes against a shadow of the last byte sent.
module uart_tx_scheduler
  import game_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int REFRESH_CYC = UART_REFRESH_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_force,
  input  logic                       tx_full,
  output logic [DATA_W-1:0]          w_data,
  output logic                       wr_uart,
  output logic [NUM_CH-1:0]          pending,
  output logic [$clog2(NUM_CH)-1:0]  grant_ch
);

  localparam int IW = $clog2(NUM_CH);

  arb_state_t        state;
  logic              write;
  logic              refresh;
  logic [NUM_CH-1:0] set_v;
  logic [NUM_CH-1:0] clr_v;
  logic [IW-1:0]     pick;
  logic              any_req;
  logic [DATA_W-1:0] chan [NUM_CH];
  logic [DATA_W-1:0] sel;

  assign write   = (state == ARB_SEND) && !tx_full;
  assign wr_uart = write;

  if (REFRESH_CYC > 0) begin : g_ref
    localparam int TW = cnt_w(REFRESH_CYC);
    localparam logic [TW-1:0] LAST = TW'(REFRESH_CYC - 1);

    logic [TW-1:0] timer;

    // free-running refresh period counter
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        timer <= '0;
      end else if (timer == LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end

    assign refresh = (timer == LAST);
  end else begin : g_noref
    assign refresh = 1'b0;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] cur;

    assign cur     = ch_data[k*DATA_W +: DATA_W];
    assign chan[k] = cur;
    assign clr_v[k] = write && (grant_ch == IW'(k));
    // on the write cycle compare against the byte going out,
    // so a change during SEND keeps the channel pending
    assign set_v[k] = ch_force[k] | refresh |
                      (cur != (clr_v[k] ? w_data : sh));

    // remember the last byte written for this channel
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sh <= '0;
      end else if (clr_v[k]) begin
        sh <= w_data;
      end
    end
  end

  // set wins over clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '1;
    end else begin
      pending <= (pending & ~clr_v) | set_v;
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (pending),
    .last    (grant_ch),
    .gnt_idx (pick),
    .any     (any_req)
  );

  assign sel = chan[pick];

  // grant, hold the byte under back-pressure, then one gap cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      w_data   <= '0;
      grant_ch <= IW'(NUM_CH - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (any_req) begin
            w_data   <= sel;
            grant_ch <= pick;
            state    <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (!tx_full) begin
            state <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, directed corner cases,
// refresh timing and a randomized run against a behavioural model.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [31:0] ch_data;
  logic [3:0]  ch_force;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic [3:0]  pending;
  logic [1:0]  grant_ch;

  logic [7:0]  rf_w_data;
  logic        rf_wr;
  logic [3:0]  rf_pend;
  logic [1:0]  rf_gnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int main_wr = 0;

  logic [15:0] cap_q [$];
  logic [15:0] rf_q [$];
  int          rf_cyc_q [$];

  typedef struct {
    logic [31:0] data;
    logic        full;
    logic        wr;
    logic [7:0]  wd;
    logic [1:0]  gr;
    logic [3:0]  pend;
  } vec_t;

  vec_t tbl [18];

  int          m_phase;
  logic [1:0]  m_last;
  logic [7:0]  m_wd;
  logic [7:0]  m_sh [4];
  logic [3:0]  m_pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_CH      (4),
    .DATA_W      (8),
    .REFRESH_CYC (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (ch_data),
    .ch_force (ch_force),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .pending  (pending),
    .grant_ch (grant_ch)
  );

  uart_tx_scheduler #(
    .NUM_CH      (4),
    .DATA_W      (8),
    .REFRESH_CYC (100)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (32'h04030201),
    .ch_force (4'b0000),
    .tx_full  (1'b0),
    .w_data   (rf_w_data),
    .wr_uart  (rf_wr),
    .pending  (rf_pend),
    .grant_ch (rf_gnt)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_cap(string nm, int n, logic [63:0] exp);
    check({nm, "_count"}, 32'(cap_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < cap_q.size()) begin
        check($sformatf("%s_%0d", nm, i), 32'(cap_q[i]),
              32'(16'(exp >> (16 * i))));
      end
    end
  endtask

  function automatic logic [7:0] chan(int k);
    return 8'(ch_data >> (8 * k));
  endfunction

  // write capture, cycle stamp and the never-write-when-full rule
  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0;
    end else begin
      if (wr_uart) begin
        cap_q.push_back({6'b0, grant_ch, w_data});
        main_wr++;
      end
      if (rf_wr) begin
        rf_q.push_back({6'b0, rf_gnt, rf_w_data});
        rf_cyc_q.push_back(cyc);
      end
      checks++;
      if (wr_uart && tx_full) begin
        errors++;
        $display("FAIL wr_while_full: got wr_uart=1 expected 0");
      end
      cyc++;
    end
  end

  task automatic m_reset();
    m_phase = 0;
    m_last  = 2'd3;
    m_wd    = 8'h00;
    m_pend  = 4'hF;
    for (int k = 0; k < 4; k++) m_sh[k] = 8'h00;
  endtask

  // spec rules: pending is set by change/force, a write clears it
  // unless the channel already moved on; grants rotate after last
  task automatic m_step();
    logic       wrote;
    logic [3:0] np;
    logic [1:0] ki;
    logic [1:0] g;
    wrote = (m_phase == 1) && !tx_full;
    for (int k = 0; k < 4; k++) begin
      ki = 2'(k);
      np[ki] = m_pend[ki] | ch_force[ki] | (chan(k) != m_sh[ki]);
    end
    if (wrote) begin
      np[m_last] = ch_force[m_last] | (chan(int'(m_last)) != m_wd);
      m_sh[m_last] = m_wd;
    end
    case (m_phase)
      0: begin
        if (m_pend != 4'h0) begin
          g = m_last;
          for (int s = 0; s < 4; s++) begin
            g = g + 2'd1;
            if (m_pend[g]) break;
          end
          m_last  = g;
          m_wd    = chan(int'(g));
          m_phase = 1;
        end
      end
      1: if (wrote) m_phase = 2;
      default: m_phase = 0;
    endcase
    m_pend = np;
  endtask

  task automatic drive_rand();
    tx_full = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        ch_data = (ch_data & ~(32'hFF << (8 * k))) |
                  (32'($urandom_range(0, 7)) << (8 * k));
      end
    end
    ch_force = 4'($urandom_range(0, 15)) &
               4'($urandom_range(0, 15)) &
               4'($urandom_range(0, 15));
  endtask

  initial begin
    int m0;

    tbl[0]  = '{32'h44332211, 1'b0, 1'b0, 8'h00, 2'd3, 4'hF};
    tbl[1]  = '{32'h44332211, 1'b0, 1'b1, 8'h11, 2'd0, 4'hF};
    tbl[2]  = '{32'h44332211, 1'b0, 1'b0, 8'h11, 2'd0, 4'hE};
    tbl[3]  = '{32'h44332211, 1'b0, 1'b0, 8'h11, 2'd0, 4'hE};
    tbl[4]  = '{32'h44332211, 1'b0, 1'b1, 8'h22, 2'd1, 4'hE};
    tbl[5]  = '{32'h44332211, 1'b0, 1'b0, 8'h22, 2'd1, 4'hC};
    tbl[6]  = '{32'h44332211, 1'b0, 1'b0, 8'h22, 2'd1, 4'hC};
    tbl[7]  = '{32'h44332211, 1'b0, 1'b1, 8'h33, 2'd2, 4'hC};
    tbl[8]  = '{32'h44332211, 1'b0, 1'b0, 8'h33, 2'd2, 4'h8};
    tbl[9]  = '{32'h44332211, 1'b0, 1'b0, 8'h33, 2'd2, 4'h8};
    tbl[10] = '{32'h44332211, 1'b0, 1'b1, 8'h44, 2'd3, 4'h8};
    tbl[11] = '{32'h44332211, 1'b0, 1'b0, 8'h44, 2'd3, 4'h0};
    tbl[12] = '{32'h44332211, 1'b0, 1'b0, 8'h44, 2'd3, 4'h0};
    tbl[13] = '{32'h44A52211, 1'b0, 1'b0, 8'h44, 2'd3, 4'h0};
    tbl[14] = '{32'h44A52211, 1'b0, 1'b0, 8'h44, 2'd3, 4'h4};
    tbl[15] = '{32'h44A52211, 1'b0, 1'b1, 8'hA5, 2'd2, 4'h4};
    tbl[16] = '{32'h44A52211, 1'b0, 1'b0, 8'hA5, 2'd2, 4'h0};
    tbl[17] = '{32'h44A52211, 1'b0, 1'b0, 8'hA5, 2'd2, 4'h0};

    rst      = 1'b1;
    ch_data  = 32'h44332211;
    ch_force = 4'h0;
    tx_full  = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset broadcast and a single-channel change
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 0) rst = 1'b1;
      ch_data = tbl[i].data;
      tx_full = tbl[i].full;
      @(negedge clk);
      check($sformatf("tbl%0d_wr", i), 32'(wr_uart), 32'(tbl[i].wr));
      check($sformatf("tbl%0d_wd", i), 32'(w_data), 32'(tbl[i].wd));
      check($sformatf("tbl%0d_gr", i), 32'(grant_ch), 32'(tbl[i].gr));
      check($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
    end

    // all channels change while the FIFO is full
    @(posedge clk);
    #1;
    cap_q.delete();
    ch_data = 32'hD4C3B2A1;
    tx_full = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("full_hold_wr", 32'(wr_uart), 32'(0));
      check("full_hold_wd", 32'(w_data), 32'(8'hD4));
      check("full_hold_gr", 32'(grant_ch), 32'(2'd3));
    end
    @(posedge clk);
    #1 tx_full = 1'b0;
    @(negedge clk);
    check("full_release_wr", 32'(wr_uart), 32'(1));
    repeat (14) @(negedge clk);
    #1;
    check_cap("full_seq", 4, 64'h02C3_01B2_00A1_03D4);

    // channel 1 moves again while its first byte is in SEND
    @(posedge clk);
    #1;
    cap_q.delete();
    ch_data = 32'hD4C310A1;
    @(posedge clk);
    @(posedge clk);
    #1 ch_data = 32'hD4C320A1;
    repeat (14) @(negedge clk);
    #1;
    check_cap("resend", 2, 64'h0000_0000_0120_0110);

    // refresh spacing on the 100-cycle instance, silence on the other
    m0 = main_wr;
    for (int i = 0; i < 600 && cyc < 390; i++) @(negedge clk);
    #1;
    check("rf_window", 32'(cyc >= 390), 32'(1));
    check("norefresh_writes", 32'(main_wr - m0), 32'(0));
    check("rf_count", 32'(rf_q.size()), 32'(16));
    for (int i = 0; i < 16 && i < rf_q.size(); i++) begin
      check($sformatf("rf_byte%0d", i), 32'(rf_q[i]),
            32'((i % 4) * 256 + (i % 4) + 1));
      check($sformatf("rf_cyc%0d", i), 32'(rf_cyc_q[i]),
            32'(1 + 100 * (i / 4) + 3 * (i % 4)));
    end

    // reset in the middle of a SEND
    @(posedge clk);
    #1 ch_force = 4'b0001;
    @(posedge clk);
    #1 ch_force = 4'b0000;
    @(posedge clk);
    #1;
    check("pre_rst_wr", 32'(wr_uart), 32'(1));
    check("pre_rst_gr", 32'(grant_ch), 32'(2'd0));
    #2 rst = 1'b0;
    #1;
    check("rst_wr", 32'(wr_uart), 32'(0));
    check("rst_pend", 32'(pending), 32'(4'hF));
    check("rst_gr", 32'(grant_ch), 32'(2'd3));
    check("rst_wd", 32'(w_data), 32'(8'h00));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cap_q.delete();
    repeat (14) @(negedge clk);
    #1;
    check_cap("post_rst", 4, 64'h03D4_02C3_0120_00A1);

    // randomized traffic against the model
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ch_data  = $urandom;
    ch_force = 4'h0;
    tx_full  = 1'b0;
    m_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      check("rnd_wr", 32'(wr_uart), 32'((m_phase == 1) && !tx_full));
      check("rnd_wd", 32'(w_data), 32'(m_wd));
      check("rnd_gr", 32'(grant_ch), 32'(m_last));
      check("rnd_pend", 32'(pending), 32'(m_pend));
      m_step();
      @(posedge clk);
      #1;
      drive_rand();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
